// File: rtl/board_reset_seq.sv
// Board reset/power sequencer: debounces reset buttons, qualifies them with PLL lock, and orders DCLO/ACLO to the CPU.
// Latency: a held, masked button falls btn_db_n 2+DB_CYCLES edges after first sample; the FSM reacts one edge later.
// Backpressure: none; this is a free-running control block with registered outputs only.
module board_reset_seq #(
  parameter int NBTN      = 3,
  parameter int DB_CYCLES = 50000,
  parameter int T_DCLO    = 256,
  parameter int T_ACLO    = 1024,
  parameter int T_PFAIL   = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBTN-1:0] btn_n,
  input  logic [NBTN-1:0] btn_mask,
  input  logic            pll_lock,
  output logic            dclo,
  output logic            aclo,
  output logic            sys_rst_n,
  output logic [2:0]      seq_state,
  output logic [NBTN-1:0] btn_db_n
);

  localparam int T_MAX = (T_DCLO >= T_ACLO) ? ((T_DCLO >= T_PFAIL) ? T_DCLO : T_PFAIL)
                                            : ((T_ACLO >= T_PFAIL) ? T_ACLO : T_PFAIL);
  localparam int SCW = $clog2(T_MAX) + 1;
  localparam int DCW = $clog2(DB_CYCLES + 1);

  localparam logic [SCW-1:0] DCLO_END  = SCW'(T_DCLO - 1);
  localparam logic [SCW-1:0] ACLO_END  = SCW'(T_ACLO - 1);
  localparam logic [SCW-1:0] PFAIL_END = SCW'(T_PFAIL - 1);
  localparam logic [DCW-1:0] DB_LAST   = DCW'(DB_CYCLES);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    DCLO_HOLD = 3'd1,
    ACLO_HOLD = 3'd2,
    RUN       = 3'd3,
    PFAIL     = 3'd4,
    OFF       = 3'd5
  } state_t;

  logic [NBTN-1:0] sync1;
  logic [NBTN-1:0] sync2;
  logic [DCW-1:0]  db_cnt [NBTN];
  logic            req;
  state_t          state;
  state_t          nxt;
  logic [SCW-1:0]  cnt;
  logic            dclo_nxt;
  logic            aclo_nxt;

  // Two-flop synchroniser for the raw asynchronous buttons; idle level is released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Per-channel debounce: the new level must stay different for DB_CYCLES cycles after it is first seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_n <= '1;
      for (int i = 0; i < NBTN; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (sync2[i] == btn_db_n[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_db_n[i] <= ~btn_db_n[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign req = |(~btn_db_n & btn_mask);

  // Next-state selection; lock loss overrides everything, req beats timer expiry in the hold states.
  always_comb begin
    nxt = state;
    if (!pll_lock) begin
      nxt = WAIT_LOCK;
    end else begin
      case (state)
        WAIT_LOCK: nxt = DCLO_HOLD;
        DCLO_HOLD: if (req) nxt = OFF; else if (cnt == DCLO_END) nxt = ACLO_HOLD;
        ACLO_HOLD: if (req) nxt = OFF; else if (cnt == ACLO_END) nxt = RUN;
        RUN:       if (req) nxt = PFAIL;
        PFAIL:     if (cnt == PFAIL_END) nxt = OFF;
        OFF:       if (!req) nxt = DCLO_HOLD;
        default:   nxt = WAIT_LOCK;
      endcase
    end
  end

  // Output levels for the state being entered, so outputs move on the same edge as the state.
  always_comb begin
    dclo_nxt = 1'b1;
    aclo_nxt = 1'b1;
    case (nxt)
      ACLO_HOLD: dclo_nxt = 1'b0;
      RUN: begin
        dclo_nxt = 1'b0;
        aclo_nxt = 1'b0;
      end
      PFAIL:     dclo_nxt = 1'b0;
      default: ;
    endcase
  end

  // Sequencer state, dwell counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      dclo      <= 1'b1;
      aclo      <= 1'b1;
      sys_rst_n <= 1'b0;
      seq_state <= 3'd0;
    end else begin
      state     <= nxt;
      dclo      <= dclo_nxt;
      aclo      <= aclo_nxt;
      sys_rst_n <= ~dclo_nxt;
      seq_state <= nxt;
      if (nxt != state) begin
        cnt <= '0;
      end else if (state == DCLO_HOLD || state == ACLO_HOLD || state == PFAIL) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_board_reset_seq.sv
// Bench for board_reset_seq: per-cycle comparison against a timeline model plus directed latency checks.
// Latency: model outputs are compared every negedge; directed checks measure edges between events.
// Backpressure: not applicable.
module tb_board_reset_seq;

  localparam int DB = 4;
  localparam int TD = 8;
  localparam int TA = 16;
  localparam int TP = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn_n = 3'b111;
  logic [2:0] btn_mask = 3'b111;
  logic       pll_lock = 1'b1;
  logic       dclo;
  logic       aclo;
  logic       sys_rst_n;
  logic [2:0] seq_state;
  logic [2:0] btn_db_n;

  board_reset_seq #(
    .NBTN(3), .DB_CYCLES(DB), .T_DCLO(TD), .T_ACLO(TA), .T_PFAIL(TP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .btn_mask(btn_mask), .pll_lock(pll_lock),
    .dclo(dclo), .aclo(aclo), .sys_rst_n(sys_rst_n), .seq_state(seq_state), .btn_db_n(btn_db_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  always @(posedge clk) edge_no++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_no);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model state numbers are the LED codes; timing is tracked as edges spent since entry.
  int       ms = 0;
  int       ment = 0;
  int       mcyc = 0;
  bit [2:0] mdb = 3'b111;
  bit [2:0] samp [0:DB+2];

  function automatic bit exp_dclo(input int s);
    return (s == 0 || s == 1 || s == 5);
  endfunction

  function automatic bit exp_aclo(input int s);
    return (s != 3);
  endfunction

  initial begin
    for (int k = 0; k <= DB + 2; k++) samp[k] = 3'b111;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ms = 0; ment = 0; mcyc = 0; mdb = 3'b111;
        for (int k = 0; k <= DB + 2; k++) samp[k] = 3'b111;
      end else begin
        bit       req;
        bit       all_diff;
        bit [2:0] newdb;
        int       dwell;
        int       ns;
        mcyc++;
        req = |(~mdb & btn_mask);
        for (int k = DB + 2; k > 0; k--) samp[k] = samp[k-1];
        samp[0] = btn_n;
        // A level is accepted once the DB+1 samples that have crossed the synchroniser all disagree with it.
        newdb = mdb;
        for (int i = 0; i < 3; i++) begin
          all_diff = 1'b1;
          for (int k = 2; k <= DB + 2; k++) if (samp[k][i] == mdb[i]) all_diff = 1'b0;
          if (all_diff) newdb[i] = ~mdb[i];
        end
        mdb = newdb;
        dwell = mcyc - ment;
        ns = ms;
        if (!pll_lock) ns = 0;
        else if (ms == 0) ns = 1;
        else if ((ms == 1 || ms == 2) && req) ns = 5;
        else if (ms == 1 && dwell == TD) ns = 2;
        else if (ms == 2 && dwell == TA) ns = 3;
        else if (ms == 3 && req) ns = 4;
        else if (ms == 4 && dwell == TP) ns = 5;
        else if (ms == 5 && !req) ns = 1;
        if (ns != ms) begin
          ms = ns;
          ment = mcyc;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("model_outputs",
          {dclo, aclo, sys_rst_n, seq_state, btn_db_n},
          {exp_dclo(ms), exp_aclo(ms), ~exp_dclo(ms), 3'(ms), mdb});
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic bit cur(input int sel);
    return (sel == 0) ? dclo : aclo;
  endfunction

  task automatic wait_sig(input string nm, input int sel, input bit val, input int lim, output int at);
    at = -1;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (cur(sel) == val) begin
        at = edge_no;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout after %0d cycles waiting for level %0d", nm, lim, val);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Release reset between edges and check the 8/16 power-up timing.
  task automatic power_up(input string tag);
    int a, t_d, t_a;
    #2 rst_n = 1'b1;
    a = edge_no + 1;
    wait_sig({tag, "_dclo_wait"}, 0, 1'b0, 100, t_d);
    chk({tag, "_dclo_edge"}, t_d - a + 1, 9);
    wait_sig({tag, "_aclo_wait"}, 1, 1'b0, 100, t_a);
    chk({tag, "_aclo_gap"}, t_a - t_d, 16);
    chk({tag, "_state_run"}, seq_state, 3);
    chk({tag, "_sys_rst_n"}, sys_rst_n, 1);
  endtask

  initial begin
    int f, r, p, t1, t2;
    cycles(3);
    chk("reset_vals", {dclo, aclo, sys_rst_n, seq_state, btn_db_n}, {1'b1, 1'b1, 1'b0, 3'd0, 3'b111});

    // 1. power-up
    power_up("pwrup");

    // 2. glitch of 3 cycles is filtered
    btn_n = 3'b101; cycles(3); btn_n = 3'b111;
    cycles(10);
    chk("glitch_db", btn_db_n, 3'b111);
    chk("glitch_aclo", aclo, 0);

    // 3. graceful power-down and re-power
    btn_n = 3'b110;
    f = edge_no + 1;
    wait_sig("pdn_aclo_wait", 1, 1'b1, 50, t1);
    chk("pdn_aclo_edge", t1 - f, 7);
    wait_sig("pdn_dclo_wait", 0, 1'b1, 100, t2);
    chk("pdn_dclo_gap", t2 - t1, 32);
    chk("pdn_state_off", seq_state, 5);
    cycles(100 - (edge_no - f + 1));
    btn_n = 3'b111;
    r = edge_no + 1;
    wait_sig("repwr_dclo_wait", 0, 1'b0, 100, t1);
    chk("repwr_dclo_edge", t1 - r, 15);
    wait_sig("repwr_aclo_wait", 1, 1'b0, 100, t2);
    chk("repwr_aclo_gap", t2 - t1, 16);

    // 4. masked channel debounces but does not request
    btn_mask = 3'b101; btn_n = 3'b101;
    cycles(10);
    chk("mask_db", btn_db_n, 3'b101);
    chk("mask_state", seq_state, 3);
    btn_n = 3'b111;
    cycles(10);
    btn_mask = 3'b111;
    cycles(2);

    // 5. one-cycle lock loss in PFAIL at count 10
    btn_n = 3'b110;
    wait_sig("lock_aclo_wait", 1, 1'b1, 50, t1);
    p = t1;
    btn_n = 3'b111;
    cycles(10);
    pll_lock = 1'b0;
    cycles(1);
    pll_lock = 1'b1;
    chk("lock_loss_edge", edge_no - p, 11);
    chk("lock_loss_out", {dclo, aclo, seq_state}, {1'b1, 1'b1, 3'd0});
    wait_sig("lock_dclo_wait", 0, 1'b0, 100, t1);
    chk("lock_dclo_edge", t1 - (p + 12), 8);
    wait_sig("lock_aclo_fall", 1, 1'b0, 100, t2);
    chk("lock_aclo_gap", t2 - t1, 16);

    // 6. asynchronous reset mid-RUN
    cycles(3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_immediate", {dclo, aclo, sys_rst_n, seq_state}, {1'b1, 1'b1, 1'b0, 3'd0});
    cycles(2);
    power_up("arst_pwrup");

    cycles(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
